// File: rtl/sram_resp_if.sv
// Request/response bus between an initiator (master) and the SRAM responder (slave).
// Data widths are fixed at 32 bits; the byte-enable field is 8 bits wide.
interface sram_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_addr,
    output req_wen,
    output req_wdata,
    output req_wmask,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_wen,
    input  req_wdata,
    input  req_wmask,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/sram_resp.sv
// Single-outstanding SRAM responder: fixed-latency read/write with byte enables,
// out-of-range error reporting and a held response until the initiator accepts it.
module sram_resp #(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  sram_resp_if.slave bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wen;
  logic [3:0]  r_wmask;
  logic        r_err;
  logic        r_rd_ok;

  logic            w_accept;
  logic            w_enter_resp;
  logic            w_resp_done;
  logic [31:0]     w_op_addr;
  logic [31:0]     w_op_wdata;
  logic            w_op_wen;
  logic [3:0]      w_op_wmask;
  logic [32:0]     w_diff;
  logic            w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0][7:0] w_rdata_q;
  logic            w_unused;

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_resp_done = (r_state == S_RESP) && bus.resp_ready;

  // The memory has no reset, so its enable is explicitly blocked while rst is high.
  assign w_enter_resp = !rst && ((w_accept && (LATENCY == 1)) ||
                                 ((r_state == S_WAIT) && (r_cnt == 4'd1)));

  // With LATENCY==1 the operation happens on the accept edge itself, before the
  // capture registers hold the request, so the live inputs are used in IDLE.
  assign w_op_addr  = (r_state == S_IDLE) ? bus.req_addr       : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? bus.req_wdata      : r_wdata;
  assign w_op_wen   = (r_state == S_IDLE) ? bus.req_wen        : r_wen;
  assign w_op_wmask = (r_state == S_IDLE) ? bus.req_wmask[3:0] : r_wmask;

  // 33-bit difference: a borrow into bit 32 marks addresses below BASE.
  assign w_diff     = {1'b0, w_op_addr} - {1'b0, BASE};
  assign w_in_range = (w_diff >> (ADDR_W + 2)) == 33'd0;
  assign w_idx      = w_diff[ADDR_W+1:2];

  assign w_unused = ^bus.req_wmask[7:4];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wen   <= 1'b0;
      r_wmask <= 4'd0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_wen   <= bus.req_wen;
        r_wmask <= bus.req_wmask[3:0];
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd1)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_err   <= !w_in_range;
        r_rd_ok <= w_in_range && !w_op_wen;
      end else if (w_resp_done) begin
        r_err   <= 1'b0;
        r_rd_ok <= 1'b0;
      end
    end
  end

  // One byte-wide array per lane gives natural byte-enable writes with a registered read.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (w_enter_resp && w_in_range) begin
          if (w_op_wen) begin
            if (w_op_wmask[gi]) begin
              r_mem[w_idx] <= w_op_wdata[gi*8 +: 8];
            end
          end else begin
            r_q <= r_mem[w_idx];
          end
        end
      end

      assign w_rdata_q[gi] = r_q;
    end
  endgenerate

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_err   = r_err;
  assign bus.resp_rdata = r_rd_ok ? w_rdata_q : 32'd0;
endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp: three instances (LATENCY 2, 4, 1) share one stimulus
// bus, and sel picks which instance receives req_valid and is observed.
module tb_sram_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic        resp_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic [1:0]  sel;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sram_resp_if b2 ();
  sram_resp_if b4 ();
  sram_resp_if b1 ();

  assign b2.req_valid  = req_valid && (sel == 2'd0);
  assign b2.req_addr   = req_addr;
  assign b2.req_wen    = req_wen;
  assign b2.req_wdata  = req_wdata;
  assign b2.req_wmask  = req_wmask;
  assign b2.resp_ready = resp_ready;

  assign b4.req_valid  = req_valid && (sel == 2'd1);
  assign b4.req_addr   = req_addr;
  assign b4.req_wen    = req_wen;
  assign b4.req_wdata  = req_wdata;
  assign b4.req_wmask  = req_wmask;
  assign b4.resp_ready = resp_ready;

  assign b1.req_valid  = req_valid && (sel == 2'd2);
  assign b1.req_addr   = req_addr;
  assign b1.req_wen    = req_wen;
  assign b1.req_wdata  = req_wdata;
  assign b1.req_wmask  = req_wmask;
  assign b1.resp_ready = resp_ready;

  sram_resp #(.LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  sram_resp #(.LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  sram_resp #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic        obs_ready;
  logic        obs_valid;
  logic        obs_err;
  logic [31:0] obs_rdata;

  assign obs_ready = (sel == 2'd0) ? b2.req_ready  : (sel == 2'd1) ? b4.req_ready  : b1.req_ready;
  assign obs_valid = (sel == 2'd0) ? b2.resp_valid : (sel == 2'd1) ? b4.resp_valid : b1.resp_valid;
  assign obs_err   = (sel == 2'd0) ? b2.resp_err   : (sel == 2'd1) ? b4.resp_err   : b1.resp_err;
  assign obs_rdata = (sel == 2'd0) ? b2.resp_rdata : (sel == 2'd1) ? b4.resp_rdata : b1.resp_rdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic use_dut(input logic [1:0] k);
    sel = k;
    #1;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!obs_ready && n < 20) begin
      tick;
      n++;
    end
    if (!obs_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", obs_ready);
    end
  endtask

  // Waits for resp_valid; returns edges from the accept edge (inclusive) to valid.
  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (!obs_valid && n < 40) begin
      tick;
      n++;
    end
    lat = n + 1;
    if (!obs_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", obs_valid);
    end
  endtask

  task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] mask, output logic [31:0] rdata, output logic err,
                     output int lat);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    req_valid = 1'b1; resp_ready = 1'b1;
    wait_ready;
    tick;
    req_valid = 1'b0;
    wait_valid(lat);
    rdata = obs_rdata;
    err   = obs_err;
    tick;
    $display("txn sel=%0d wen=%b addr=%h wdata=%h mask=%h -> rdata=%h err=%b lat=%0d",
             sel, wen, addr, wdata, mask, rdata, err, lat);
  endtask

  task automatic test_reset;
    int n;
    for (int k = 0; k < 3; k++) begin
      use_dut(2'(k));
      checks++;
      if (obs_ready !== 1'b1) begin errors++; $display("FAIL rst_ready dut%0d: got %b required 1", k, obs_ready); end
      checks++;
      if (obs_valid !== 1'b0) begin errors++; $display("FAIL rst_valid dut%0d: got %b required 0", k, obs_valid); end
      checks++;
      if (obs_rdata !== 32'd0 || obs_err !== 1'b0) begin
        errors++; $display("FAIL rst_data dut%0d: rdata=%h err=%b required 0/0", k, obs_rdata, obs_err);
      end
    end
    // Request already pending when reset releases: accepted on the very next edge.
    use_dut(2'd1);
    req_wen = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'h1234_5678; req_wmask = 8'h0F;
    req_valid = 1'b1;
    rst = 1'b0;
    tick;
    req_valid = 1'b0;
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL accept_after_reset: req_ready=%b required 0", obs_ready); end
    wait_valid(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL lat4_first: got %0d required 4", n); end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    $display("reset test done");
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat;
    use_dut(2'd0);
    txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, rd, er, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d required 2", lat); end
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL wr_resp: rdata=%h err=%b required 0/0", rd, er); end
    txn(1'b0, 32'h8000_0010, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL rd_data: rdata=%h err=%b required DEADBEEF/0", rd, er); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rd_lat: got %0d required 2", lat); end
  endtask

  task automatic test_partial_mask;
    logic [31:0] rd; logic er; int lat;
    use_dut(2'd0);
    txn(1'b1, 32'h8000_0010, 32'h1122_3344, 8'h05, rd, er, lat);
    txn(1'b0, 32'h8000_0010, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL mask05: rdata=%h required DE22BE44", rd); end
    // Only wmask[3:0] matters; F0 enables nothing but still responds normally.
    txn(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL mask_zero_resp: rdata=%h err=%b lat=%0d required 0/0/2", rd, er, lat);
    end
    txn(1'b0, 32'h8000_0013, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL mask_zero_read: rdata=%h required DE22BE44", rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er; int lat;
    use_dut(2'd0);
    txn(1'b1, 32'h8000_0000, 32'hA5A5_0000, 8'h0F, rd, er, lat);
    txn(1'b1, 32'h8000_0FFC, 32'h5A5A_0FFC, 8'h0F, rd, er, lat);
    txn(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1 || lat !== 2) begin
      errors++; $display("FAIL oor_low_rd: rdata=%h err=%b lat=%0d required 0/1/2", rd, er, lat);
    end
    txn(1'b0, 32'h8000_1000, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1 || lat !== 2) begin
      errors++; $display("FAIL oor_high_rd: rdata=%h err=%b lat=%0d required 0/1/2", rd, er, lat);
    end
    txn(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL oor_high_wr: rdata=%h err=%b required 0/1", rd, er); end
    txn(1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 8'h0F, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL oor_low_wr: rdata=%h err=%b required 0/1", rd, er); end
    txn(1'b0, 32'h8000_0000, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hA5A5_0000 || er !== 1'b0) begin errors++; $display("FAIL oor_word0: rdata=%h err=%b required A5A50000/0", rd, er); end
    txn(1'b0, 32'h8000_0FFC, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h5A5A_0FFC || er !== 1'b0) begin errors++; $display("FAIL oor_wordlast: rdata=%h err=%b required 5A5A0FFC/0", rd, er); end
  endtask

  task automatic test_backpressure;
    int lat;
    use_dut(2'd0);
    req_wen = 1'b0; req_addr = 32'h8000_0010; req_wdata = 32'h0; req_wmask = 8'h0;
    req_valid = 1'b1; resp_ready = 1'b0;
    wait_ready;
    tick;
    req_valid = 1'b0;
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_valid !== 1'b1 || obs_rdata !== 32'hDE22_BE44 || obs_err !== 1'b0 || obs_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: valid=%b rdata=%h err=%b ready=%b required 1/DE22BE44/0/0",
                 i, obs_valid, obs_rdata, obs_err, obs_ready);
      end
      tick;
    end
    resp_ready = 1'b1;
    tick;
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b required 0/1", obs_valid, obs_ready);
    end
    resp_ready = 1'b0;
    $display("backpressure test done");
  endtask

  task automatic test_reset_wait;
    logic [31:0] rd; logic er; int lat;
    use_dut(2'd1);
    req_wen = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'hCAFE_F00D; req_wmask = 8'h0F;
    req_valid = 1'b1; resp_ready = 1'b1;
    wait_ready;
    tick;
    req_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wait_async: valid=%b ready=%b required 0/1", obs_valid, obs_ready);
    end
    tick;
    rst = 1'b0;
    txn(1'b0, 32'h8000_0000, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1234_5678 || er !== 1'b0 || lat !== 4) begin
      errors++; $display("FAIL rst_wait_old: rdata=%h err=%b lat=%0d required 12345678/0/4", rd, er, lat);
    end
    // Reset while in RESP: the write already done on entry must survive.
    req_wen = 1'b1; req_addr = 32'h8000_0004; req_wdata = 32'h0BAD_C0DE; req_wmask = 8'h0F;
    req_valid = 1'b1; resp_ready = 1'b0;
    wait_ready;
    tick;
    req_valid = 1'b0;
    wait_valid(lat);
    rst = 1'b1;
    #1;
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_drop: valid=%b required 0", obs_valid); end
    tick;
    rst = 1'b0;
    txn(1'b0, 32'h8000_0004, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0BAD_C0DE) begin errors++; $display("FAIL rst_resp_kept: rdata=%h required 0BADC0DE", rd); end
    use_dut(2'd0);
    txn(1'b0, 32'h8000_0010, 32'h0, 8'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL rst_array_kept: rdata=%h required DE22BE44", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat; int accepts;
    use_dut(2'd2);
    txn(1'b1, 32'h8000_0020, 32'h1111_2222, 8'h0F, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b0) begin errors++; $display("FAIL lat1_wr: lat=%0d err=%b required 1/0", lat, er); end
    req_wen = 1'b0; req_addr = 32'h8000_0020; req_valid = 1'b1; resp_ready = 1'b1;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_ready !== ((i % 2) == 0) || obs_valid !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL b2b cyc%0d: ready=%b valid=%b required %b/%b", i, obs_ready, obs_valid,
                 (i % 2) == 0, (i % 2) == 1);
      end
      if ((i % 2) == 1) begin
        checks++;
        if (obs_rdata !== 32'h1111_2222) begin errors++; $display("FAIL b2b_data cyc%0d: rdata=%h required 11112222", i, obs_rdata); end
      end
      if (obs_ready && req_valid) accepts++;
      $display("b2b cyc%0d ready=%b valid=%b rdata=%h", i, obs_ready, obs_valid, obs_rdata);
      if (i == 7) req_valid = 1'b0;
      tick;
    end
    checks++;
    if (accepts !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d required 4", accepts); end
    checks++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: ready=%b valid=%b required 1/0", obs_ready, obs_valid);
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_wmask = 8'h0;
    repeat (2) tick;
    test_reset;
    test_write_read;
    test_partial_mask;
    test_out_of_range;
    test_backpressure;
    test_reset_wait;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; the memory holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to resp_valid; legal range is 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-009 SHALL have port req_wen, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port req_wdata, input, 32 bits: write data.
REQ-011 SHALL have port req_wmask, input, 8 bits: byte enables; bit i enables byte i; bits [7:4] are ignored.
REQ-012 SHALL have port resp_valid, output, 1 bit: a response is available.
REQ-013 SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 SHALL have port resp_rdata, output, 32 bits: read data; 0 for writes and errors.
REQ-015 SHALL have port resp_err, output, 1 bit: the address was outside [BASE, BASE + 4*2^ADDR_W).

Function
REQ-016 SHALL implement an FSM with three states: IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL drive resp_valid=1 only in RESP.
REQ-019 SHALL accept a request at a rising edge where req_valid&&req_ready, capturing addr, wen, wdata and wmask into internal registers.
REQ-020 SHALL, on accept, load the counter with LATENCY-1 and go to RESP if LATENCY==1, else to WAIT.
REQ-021 SHALL, in WAIT, go to RESP when the counter equals 1, else decrement the counter.
REQ-022 SHALL perform the memory operation at the edge that enters RESP: a write updates only the enabled bytes, and a read loads resp_rdata from the array.
REQ-023 SHALL therefore assert resp_valid exactly LATENCY cycles after the accept edge.
REQ-024 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready is sampled high, then go to IDLE at that edge and clear resp_valid.
REQ-025 SHALL give a minimum request spacing of LATENCY+1 cycles; no request is accepted in the same cycle as a response handshake.
REQ-026 SHALL, for an out-of-range address, perform no array write, return resp_rdata=0 and resp_err=1, with the same timing as an in-range request.
REQ-027 SHALL return resp_rdata=0 and resp_err=0 for an in-range write.
REQ-028 SHALL leave the array unchanged for a write with wmask[3:0]=0, which still produces a normal response.
REQ-029 SHALL compute the word index as (addr-BASE)>>2 over ADDR_W bits.
REQ-030 SHALL make a read observe all writes whose responses were issued earlier.
REQ-031 SHALL ignore req_valid and all request inputs while not in IDLE; the initiator must hold them until accepted.

Reset
REQ-032 SHALL, while rst is high, asynchronously force state=IDLE, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready becomes 1 once in IDLE.
REQ-033 SHALL not reset the array contents.
REQ-034 SHALL, on reset asserted in WAIT, abandon the pending request; a pending write is not performed.
REQ-035 SHALL, on reset asserted in RESP, drop the response; a write already performed on entry to RESP stays in the array.
REQ-036 SHALL accept a request at the first rising edge after rst deasserts if req_valid=1.

Verification
REQ-037 SHALL cover write then read, LATENCY=2: write addr 8000_0010, data DEADBEEF, mask 0F -> resp_valid 2 cycles after accept, err=0, rdata=0; read 8000_0010 -> rdata=DEADBEEF.
REQ-038 SHALL cover partial mask: over DEADBEEF, write data 11223344 with mask 05 -> a read returns DE22BE44.
REQ-039 SHALL cover out of range: read 7FFF_FFFC and read 8000_1000 (ADDR_W=10) -> err=1, rdata=0; a write there leaves every word unchanged.
REQ-040 SHALL cover backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err held, req_ready=0; resp_ready=1 -> IDLE next cycle, req_ready=1.
REQ-041 SHALL cover reset mid-WAIT with LATENCY=4: write 8000_0000=CAFEF00D, assert rst 1 cycle after accept -> resp_valid=0; a later read of 8000_0000 returns the old value.
REQ-042 SHALL cover LATENCY=1 back-to-back with resp_ready=1 and req_valid held: resp_valid high in the cycle after each accept, with accepts every 2 cycles.
